// File: rtl/afe_threshold_flagger.sv
// afe_threshold_flagger
//
// Per-channel threshold/hysteresis detector on the synchronized ADC sample
// stream. Each sample is captured (stage 1), then checked against the
// addressed channel's state (stage 2). A crossing becomes a flag once enough
// consecutive qualifying samples have arrived on that channel.
//
// Optional feature macro: AFE_FLAG_DEBOUNCE_EN
//   defined   : per-channel debounce counters, cfg_debounce_i honoured
//   undefined : no counters, every qualifying sample transitions at once
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   cfg_en_i        detector enable; low clears all channel state
//   cfg_ch_mask_i   per-channel participate mask
//   cfg_thr_hi_i    signed high threshold (LOW -> HIGH when sample > thr_hi)
//   cfg_thr_lo_i    signed low threshold  (HIGH -> LOW when sample < thr_lo)
//   cfg_debounce_i  consecutive qualifying samples required (0 acts as 1)
//   adc_rx_valid_i  sample valid pulse
//   adc_rx_data_i   sample word (sample in low bits, channel id at CH_ID_LSB)
//   flags_valid_o   one-cycle flag pulse
//   flags_o         bit0 rising crossing, bit1 falling crossing
//   flags_chid_o    channel of the flag
module afe_threshold_flagger #(
  parameter int ADC_DATA_WIDTH = 32,
  parameter int ADC_NUM_CHS    = 8,
  parameter int CH_ID_LSB      = 28,
  parameter int CH_ID_WIDTH    = 4,
  parameter int SAMPLE_WIDTH   = 16,
  parameter int CNT_WIDTH      = 4,
  parameter int FLAG_WIDTH     = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cfg_en_i,
  input  logic [ADC_NUM_CHS-1:0]    cfg_ch_mask_i,
  input  logic [SAMPLE_WIDTH-1:0]   cfg_thr_hi_i,
  input  logic [SAMPLE_WIDTH-1:0]   cfg_thr_lo_i,
  input  logic [CNT_WIDTH-1:0]      cfg_debounce_i,
  input  logic                      adc_rx_valid_i,
  input  logic [ADC_DATA_WIDTH-1:0] adc_rx_data_i,
  output logic                      flags_valid_o,
  output logic [FLAG_WIDTH-1:0]     flags_o,
  output logic [CH_ID_WIDTH-1:0]    flags_chid_o
);

  localparam int IDX_W = (ADC_NUM_CHS > 1) ? $clog2(ADC_NUM_CHS) : 1;

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  // ---------------------------------------------------------------- stage 1
  logic                           s1_valid_reg;
  logic signed [SAMPLE_WIDTH-1:0] s1_sample_reg;
  logic [CH_ID_WIDTH-1:0]         s1_chid_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_reg  <= 1'b0;
      s1_sample_reg <= '0;
      s1_chid_reg   <= '0;
    end else begin
      s1_valid_reg <= adc_rx_valid_i;
      if (adc_rx_valid_i) begin
        s1_sample_reg <= adc_rx_data_i[SAMPLE_WIDTH-1:0];
        s1_chid_reg   <= adc_rx_data_i[CH_ID_LSB +: CH_ID_WIDTH];
      end
    end
  end

  // Bits between the sample and channel-id fields carry nothing for us.
  logic data_unused;
  assign data_unused = ^adc_rx_data_i;

  // ---------------------------------------------------------------- stage 2
  logic                           chid_in_range;
  logic [IDX_W-1:0]               ch_idx;
  logic                           eval;
  logic signed [SAMPLE_WIDTH-1:0] thr_hi_s;
  logic signed [SAMPLE_WIDTH-1:0] thr_lo_s;
  logic                           above_hi;
  logic                           below_lo;

  assign chid_in_range = (32'(s1_chid_reg) < 32'(ADC_NUM_CHS));
  assign ch_idx        = s1_chid_reg[IDX_W-1:0];
  // cfg_en_i gates evaluation, so a sample sitting in stage 1 while the
  // enable drops is simply dropped.
  assign eval          = s1_valid_reg & cfg_en_i & chid_in_range & cfg_ch_mask_i[ch_idx];
  assign thr_hi_s      = cfg_thr_hi_i;
  assign thr_lo_s      = cfg_thr_lo_i;
  assign above_hi      = (s1_sample_reg > thr_hi_s);
  assign below_lo      = (s1_sample_reg < thr_lo_s);

`ifdef AFE_FLAG_DEBOUNCE_EN
  logic [CNT_WIDTH-1:0] deb_eff;
  assign deb_eff = (cfg_debounce_i == '0) ? CNT_WIDTH'(1) : cfg_debounce_i;
`else
  logic debounce_unused;
  assign debounce_unused = ^cfg_debounce_i;
`endif

  logic [ADC_NUM_CHS-1:0] rise_vec;
  logic [ADC_NUM_CHS-1:0] fall_vec;

  genvar gi;
  generate
    for (gi = 0; gi < ADC_NUM_CHS; gi++) begin : g_ch
      state_t state_reg;
      state_t state_next;
      logic   hit;
      logic   qualify;
      logic   fire;

      assign hit     = eval && (ch_idx == IDX_W'(gi));
      assign qualify = (state_reg == ST_LOW) ? above_hi : below_lo;

`ifdef AFE_FLAG_DEBOUNCE_EN
      logic [CNT_WIDTH-1:0] cnt_reg;
      logic [CNT_WIDTH-1:0] cnt_next;

      // Compare cnt+1 one bit wider so the threshold test cannot wrap; the
      // transition fires at cnt+1 == deb_eff, so cnt_reg never overflows.
      assign fire = hit && qualify &&
                    (({1'b0, cnt_reg} + 1'b1) >= {1'b0, deb_eff});

      always_comb begin
        cnt_next = cnt_reg;
        if (!cfg_en_i) begin
          cnt_next = '0;
        end else if (hit) begin
          if (!qualify || fire) begin
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
`else
      assign fire = hit && qualify;
`endif

      always_comb begin
        state_next = state_reg;
        if (!cfg_en_i) begin
          state_next = ST_LOW;
        end else if (fire) begin
          state_next = (state_reg == ST_LOW) ? ST_HIGH : ST_LOW;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_reg <= ST_LOW;
        end else begin
          state_reg <= state_next;
        end
      end

      assign rise_vec[gi] = fire && (state_reg == ST_LOW);
      assign fall_vec[gi] = fire && (state_reg == ST_HIGH);
    end
  endgenerate

  // ---------------------------------------------------------------- outputs
  // At most one channel is addressed per cycle, so OR-reducing is exact.
  logic                   flag_any;
  logic                   flags_valid_reg;
  logic [FLAG_WIDTH-1:0]  flags_reg;
  logic [CH_ID_WIDTH-1:0] flags_chid_reg;

  assign flag_any = |(rise_vec | fall_vec);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flags_valid_reg <= 1'b0;
      flags_reg       <= '0;
      flags_chid_reg  <= '0;
    end else begin
      flags_valid_reg <= flag_any;
      flags_reg       <= FLAG_WIDTH'({|fall_vec, |rise_vec});
      flags_chid_reg  <= flag_any ? s1_chid_reg : '0;
    end
  end

  assign flags_valid_o = flags_valid_reg;
  assign flags_o       = flags_reg;
  assign flags_chid_o  = flags_chid_reg;

endmodule

// File: tb/tb_afe_threshold_flagger.sv
// tb_afe_threshold_flagger
//
// Directed scenarios followed by a randomized phase. A behavioural model of
// the detector (per-channel high/low flag and consecutive-sample count, plus
// a one-deep capture stage) predicts the outputs after every clock edge.
// Honours AFE_FLAG_DEBOUNCE_EN the same way the design does.
`timescale 1ns/1ps
module tb_afe_threshold_flagger;

  localparam int NCH = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [7:0]  cfg_ch_mask_i;
  logic [15:0] cfg_thr_hi_i;
  logic [15:0] cfg_thr_lo_i;
  logic [3:0]  cfg_debounce_i;
  logic        adc_rx_valid_i;
  logic [31:0] adc_rx_data_i;
  logic        flags_valid_o;
  logic [1:0]  flags_o;
  logic [3:0]  flags_chid_o;

  always #5 clk = ~clk;

  afe_threshold_flagger dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cfg_en_i       (cfg_en_i),
    .cfg_ch_mask_i  (cfg_ch_mask_i),
    .cfg_thr_hi_i   (cfg_thr_hi_i),
    .cfg_thr_lo_i   (cfg_thr_lo_i),
    .cfg_debounce_i (cfg_debounce_i),
    .adc_rx_valid_i (adc_rx_valid_i),
    .adc_rx_data_i  (adc_rx_data_i),
    .flags_valid_o  (flags_valid_o),
    .flags_o        (flags_o),
    .flags_chid_o   (flags_chid_o)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit m_high [NCH];
  int m_cnt  [NCH];
  bit p_valid;
  int p_chid;
  int p_sample;
  bit e_valid;
  int e_flags;
  int e_chid;

  int rise_cnt;
  int fall_cnt;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear_channels();
    for (int c = 0; c < NCH; c++) begin
      m_high[c] = 1'b0;
      m_cnt[c]  = 0;
    end
  endfunction

  // What happens at one rising clock edge, from the input values present now.
  function automatic void model_edge();
    int deb;
    int s;
    int hi;
    int lo;
    int c;
    e_valid = 1'b0;
    e_flags = 0;
    e_chid  = 0;
    if (rst_i) begin
      model_clear_channels();
      p_valid = 1'b0;
      return;
    end
    if (!cfg_en_i) begin
      model_clear_channels();
    end else if (p_valid && p_chid < NCH && cfg_ch_mask_i[p_chid]) begin
`ifdef AFE_FLAG_DEBOUNCE_EN
      deb = (cfg_debounce_i == 4'd0) ? 1 : int'(cfg_debounce_i);
`else
      deb = 1;
`endif
      c  = p_chid;
      s  = p_sample;
      hi = $signed(cfg_thr_hi_i);
      lo = $signed(cfg_thr_lo_i);
      if (!m_high[c]) begin
        if (s > hi) begin
          m_cnt[c]++;
          if (m_cnt[c] >= deb) begin
            m_high[c] = 1'b1;
            m_cnt[c]  = 0;
            e_valid   = 1'b1;
            e_flags   = 1;
            e_chid    = c;
          end
        end else begin
          m_cnt[c] = 0;
        end
      end else begin
        if (s < lo) begin
          m_cnt[c]++;
          if (m_cnt[c] >= deb) begin
            m_high[c] = 1'b0;
            m_cnt[c]  = 0;
            e_valid   = 1'b1;
            e_flags   = 2;
            e_chid    = c;
          end
        end else begin
          m_cnt[c] = 0;
        end
      end
    end
    p_valid  = adc_rx_valid_i;
    p_chid   = int'(adc_rx_data_i[31:28]);
    p_sample = $signed(adc_rx_data_i[15:0]);
  endfunction

  // One clock: update model at the edge, compare just after it, return at negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("flags_valid", 32'(flags_valid_o), 32'(e_valid));
    check("flags", 32'(flags_o), 32'(e_flags));
    check("flags_chid", 32'(flags_chid_o), 32'(e_chid));
    if (flags_valid_o === 1'b1 && flags_o[0] === 1'b1) rise_cnt++;
    if (flags_valid_o === 1'b1 && flags_o[1] === 1'b1) fall_cnt++;
    $display("[TB] t=%0t v=%0b flags=%0d chid=%0d exp v=%0b flags=%0d chid=%0d",
             $time, flags_valid_o, flags_o, flags_chid_o, e_valid, e_flags, e_chid);
    @(negedge clk);
  endtask

  task automatic idle(int n);
    adc_rx_valid_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(int ch, int s);
    adc_rx_valid_i = 1'b1;
    adc_rx_data_i  = {4'(ch), 12'h000, 16'(s)};
    tick();
    adc_rx_valid_i = 1'b0;
    adc_rx_data_i  = '0;
  endtask

  task automatic clear_counts();
    rise_cnt = 0;
    fall_cnt = 0;
  endtask

  initial begin
    int r;
    int tmp;
    int ch;
    int sv;

    p_valid = 1'b0;
    p_chid  = 0;
    p_sample = 0;
    model_clear_channels();
    clear_counts();

    rst_i          = 1'b1;
    cfg_en_i       = 1'b1;
    cfg_ch_mask_i  = 8'hFF;
    cfg_thr_hi_i   = 16'd100;
    cfg_thr_lo_i   = 16'hFF9C;  // -100
    cfg_debounce_i = 4'd0;
    adc_rx_valid_i = 1'b0;
    adc_rx_data_i  = '0;

    @(negedge clk);
    idle(2);
    check("reset_valid", 32'(flags_valid_o), 32'd0);
    check("reset_flags", 32'(flags_o), 32'd0);
    check("reset_chid", 32'(flags_chid_o), 32'd0);
    rst_i = 1'b0;
    idle(1);

    // First flag: ch3 sample 101, flag visible after the following edge
    send(3, 101);
    idle(1);
    check("first_valid", 32'(flags_valid_o), 32'd1);
    check("first_flags", 32'(flags_o), 32'd1);
    check("first_chid", 32'(flags_chid_o), 32'd3);
    idle(1);
    check("first_pulse_width", 32'(flags_valid_o), 32'd0);

    // Debounce 3 on ch1
    cfg_debounce_i = 4'd3;
    clear_counts();
    send(1, 200); send(1, 200); send(1, 50);
    send(1, 200); send(1, 200); send(1, 200);
    idle(2);
    check("deb3_rise_count", 32'(rise_cnt), 32'd1);
    clear_counts();
    send(1, -101); send(1, -101); send(1, -101);
    idle(2);
    check("deb3_fall_count", 32'(fall_cnt), 32'd1);

    // Interleaving with debounce 2
    cfg_debounce_i = 4'd2;
    clear_counts();
    send(0, 150); send(5, 150); send(0, 150);
    idle(2);
`ifdef AFE_FLAG_DEBOUNCE_EN
    check("interleave_rise_count", 32'(rise_cnt), 32'd1);
`else
    check("interleave_rise_count", 32'(rise_cnt), 32'd2);
`endif
    send(5, 150);
    idle(2);
    check("interleave_ch5_total", 32'(rise_cnt), 32'd2);

    // Boundaries and filtering, debounce 0
    cfg_debounce_i = 4'd0;
    clear_counts();
    send(6, 100);
    idle(2);
    check("boundary_hi_equal", 32'(rise_cnt), 32'd0);
    send(6, 500);
    idle(2);
    check("boundary_ch6_rise", 32'(rise_cnt), 32'd1);
    send(6, -100);
    idle(2);
    check("boundary_lo_equal", 32'(fall_cnt), 32'd0);
    clear_counts();
    send(9, 500); send(9, -500);
    idle(2);
    check("chid9_filtered", 32'(rise_cnt + fall_cnt), 32'd0);
    cfg_ch_mask_i = 8'hFB;
    send(2, 500);
    idle(2);
    check("masked_ch2", 32'(rise_cnt), 32'd0);
    cfg_ch_mask_i = 8'hFF;
    send(2, 500);
    idle(2);
    check("unmasked_ch2_still_low", 32'(rise_cnt), 32'd1);

    // Disable pulse concurrent with a ch4 falling sample
    send(4, 500);
    idle(2);
    clear_counts();
    cfg_en_i       = 1'b0;
    adc_rx_valid_i = 1'b1;
    adc_rx_data_i  = {4'd4, 12'h000, 16'hFE0C};  // -500
    tick();
    cfg_en_i       = 1'b1;
    adc_rx_valid_i = 1'b0;
    adc_rx_data_i  = '0;
    idle(2);
    check("disable_no_fall", 32'(fall_cnt), 32'd0);
    send(4, 500);
    idle(2);
    check("disable_back_to_low", 32'(rise_cnt), 32'd1);

    // Reset while a qualifying sample sits in stage 1
    clear_counts();
    send(7, 500);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    idle(2);
    check("rst_mid_no_flag", 32'(rise_cnt), 32'd0);
    cfg_debounce_i = 4'd5;
    send(7, 500);
    idle(2);
`ifdef AFE_FLAG_DEBOUNCE_EN
    check("rst_mid_debounce5", 32'(rise_cnt), 32'd0);
`else
    check("rst_mid_debounce5", 32'(rise_cnt), 32'd1);
`endif

    // Randomized phase
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      rst_i    = (r < 1);
      cfg_en_i = !(r >= 1 && r < 4);
      if ($urandom_range(0, 19) == 0) cfg_debounce_i = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) cfg_ch_mask_i = 8'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        tmp = $urandom_range(0, 200);
        cfg_thr_hi_i = 16'(tmp - 100);
        tmp = $urandom_range(0, 200);
        cfg_thr_lo_i = 16'(tmp - 100);
      end
      adc_rx_valid_i = ($urandom_range(0, 9) < 7);
      ch = $urandom_range(0, 9);
      case ($urandom_range(0, 4))
        0: sv = $signed(cfg_thr_hi_i);
        1: sv = $signed(cfg_thr_hi_i) + 1;
        2: sv = $signed(cfg_thr_lo_i);
        3: sv = $signed(cfg_thr_lo_i) - 1;
        default: sv = $signed(16'($urandom));
      endcase
      adc_rx_data_i = {4'(ch), 12'(($urandom)), 16'(sv)};
      tick();
    end
    rst_i = 1'b0;
    cfg_en_i = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/afe_threshold_flagger.md
# afe_threshold_flagger

Per-channel threshold/hysteresis detector on the synchronized ADC sample stream. It sits between the ADC synchronizer and the ADC top. It consumes the synchronized sample valid/data pair and produces the flag valid/flag/channel-id triple used for flag events in the ADC top. Each sample is compared against a high and a low threshold. A crossing becomes a flag only after the configured number of consecutive qualifying samples on the same channel.

## Interface
- ADC_DATA_WIDTH, 32, width of the synchronized ADC word
- ADC_NUM_CHS, 8, number of channels tracked; one state bit and one counter per channel
- CH_ID_LSB, 28, LSB of the channel-id field in the ADC word
- CH_ID_WIDTH, 4, width of the channel-id field
- SAMPLE_WIDTH, 16, sample field = ADC word bits [SAMPLE_WIDTH-1:0], two's complement
- CNT_WIDTH, 4, debounce counter width
- FLAG_WIDTH, 2, bit0 = rising crossing, bit1 = falling crossing

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset; synchronous, active-high
- cfg_en_i  in  1  detector enable
- cfg_ch_mask_i  in  ADC_NUM_CHS  1 = channel participates
- cfg_thr_hi_i  in  SAMPLE_WIDTH  signed high threshold
- cfg_thr_lo_i  in  SAMPLE_WIDTH  signed low threshold
- cfg_debounce_i  in  CNT_WIDTH  consecutive samples required; 0 is treated as 1
- adc_rx_valid_i  in  1  synchronized sample valid; single-cycle pulse, no backpressure
- adc_rx_data_i  in  ADC_DATA_WIDTH  synchronized sample word
- flags_valid_o  out  1  flag pulse, one cycle
- flags_o  out  FLAG_WIDTH  flag bits; 0 when flags_valid_o = 0
- flags_chid_o  out  CH_ID_WIDTH  channel of the flag; 0 when flags_valid_o = 0

## Operation
- **Stage 1 (capture):**
  - On adc_rx_valid_i, register the sample field, the chid = data[CH_ID_LSB +: CH_ID_WIDTH], and a stage-1 valid bit.
  - With no input valid, the stage-1 valid bit clears.
- **Stage 2 (evaluate):** runs when the stage-1 valid bit is set, cfg_en_i = 1, chid < ADC_NUM_CHS, and cfg_ch_mask_i[chid] = 1. Otherwise nothing is updated and no flag is produced.
- **Per-channel FSM**, two states, reset state LOW:
  - LOW, sample > thr_hi (strict, signed): cnt++.
    - If cnt+1 ≥ max(debounce, 1): go to HIGH, cnt = 0, emit flag 2'b01.
  - LOW, sample ≤ thr_hi: cnt = 0.
  - HIGH, sample < thr_lo (strict, signed): cnt++.
    - If cnt+1 ≥ max(debounce, 1): go to LOW, cnt = 0, emit flag 2'b10.
  - HIGH, sample ≥ thr_lo: cnt = 0.
- **Counter:** never exceeds 2^CNT_WIDTH−1; the transition fires before the counter can wrap.
- **Channel isolation:** samples of other channels do not touch a channel's counter.
- **Threshold ordering:** thr_lo > thr_hi is legal and needs no special handling; the rules above apply literally.
- **Disable:** cfg_en_i = 0 clears all states to LOW, clears all counters, and suppresses flags while low.
- **Mask clear:** clearing a channel's mask bit freezes that channel's state and counter; nothing is cleared.
- **Configuration sampling:** thresholds, mask and debounce are sampled at stage 2. A change takes effect on the next evaluated sample.

## Timing
- **Reset values:** flags_valid_o = 0, flags_o = 0, flags_chid_o = 0, all states LOW, all counters 0, stage-1 valid bit 0.
- **Latency:** flags_valid_o rises exactly 2 cycles after the adc_rx_valid_i edge that produced the flag. All flag outputs are registered.
- **Throughput:** back-to-back valid samples (one per cycle) are fully supported.
- **Reset mid-pipeline:** a sample in stage 1 when rst_i is asserted is discarded, and no flag is produced for it.
- **cfg_en_i falling:** a sample in stage 1 while cfg_en_i falls is discarded in the same cycle.
- **Same-channel back-to-back:** consecutive same-channel samples in consecutive cycles see the updated state (read-modify-write within stage 2, no hazard).

## Configuration
- **AFE_FLAG_DEBOUNCE_EN defined:** per-channel CNT_WIDTH counters are built and the debounce behaviour is as described above.
- **AFE_FLAG_DEBOUNCE_EN undefined:**
  - No counters are built and cfg_debounce_i is ignored.
  - Every qualifying sample transitions immediately (behaviour identical to debounce = 1).
  - Latency and ports are unchanged.

## Test plan
- **Reset:** after rst_i, hold cfg_en_i = 1, mask = 8'hFF, thr_hi = 100, thr_lo = −100, debounce = 0. Then send ch3 sample 101 → flags_valid_o pulses 2 cycles later with flags_o = 2'b01, flags_chid_o = 3.
- **Debounce 3:** ch1 samples 200, 200, 50, 200, 200, 200 → exactly one 2'b01 flag, 2 cycles after the 6th sample. Then ch1 samples −101 ×3 → one 2'b10 flag.
- **Interleaving:** debounce = 2, samples ch0 = 150, ch5 = 150, ch0 = 150 → flag only for ch0, after the 3rd sample. ch5's counter stays at 1.
- **Boundary and filtering:**
  - Sample exactly 100 in LOW gives no flag; sample exactly −100 in HIGH gives no flag.
  - A chid = 9 word gives no flag.
  - ch2 masked gives no flag and no state change.
- **Disable:** with ch4 in HIGH, pulse cfg_en_i = 0 for one cycle, concurrent with a ch4 sample of −500 → no flag. Then ch4 sample 500 → 2'b01 flag, proving state returned to LOW.
- **Reset mid-pipeline:** assert rst_i the cycle after a qualifying valid → flags_valid_o stays 0. Run the same test with the macro undefined and debounce = 5 → a single qualifying sample flags.
